// File: rtl/cache_control_nway.sv
// Controller for an N-way write-back, write-allocate L1 cache with tree pseudo-LRU replacement.
// Hits finish in the request cycle. Misses go through WRITE_BACK (dirty victims only), then FILL, then INSTALL.
module cache_control_nway #(
  parameter int NUM_WAYS = 4,
  parameter int WAY_W    = $clog2(NUM_WAYS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mem_read,
  input  logic                mem_write,
  output logic                mem_resp,
  input  logic [NUM_WAYS-1:0] hit_vec,
  input  logic [NUM_WAYS-1:0] valid_vec,
  input  logic [NUM_WAYS-1:0] dirty_vec,
  input  logic [NUM_WAYS-2:0] lru_bits,
  output logic                lru_load,
  output logic [NUM_WAYS-2:0] lru_new,
  output logic [WAY_W-1:0]    way_sel,
  output logic [NUM_WAYS-1:0] data_load,
  output logic [NUM_WAYS-1:0] valid_set,
  output logic [NUM_WAYS-1:0] dirty_set,
  output logic [NUM_WAYS-1:0] dirty_clr,
  output logic                datawritemux_sel,
  output logic                pmemaddrmux_sel,
  output logic                pmdr_load,
  output logic                pmem_read,
  output logic                pmem_write,
  input  logic                pmem_resp
);

  typedef enum logic [1:0] {CHECK, WRITE_BACK, FILL, INSTALL} state_t;

  state_t           state_q, state_d;
  logic [WAY_W-1:0] victim_q, victim_d;
  logic [WAY_W-1:0] hit_way, inv_way, plru_way, miss_victim;
  logic             req, hit, any_inv;

  function automatic logic [NUM_WAYS-2:0] touch(input logic [NUM_WAYS-2:0] bits,
                                                input logic [WAY_W-1:0]    w);
    logic [WAY_W-1:0] node;
    logic [WAY_W-1:0] ws;
    logic             d;
    touch = bits;
    node  = '0;
    ws    = w;
    // Walk root to leaf; each node on the path is pointed at the half not containing w.
    for (int l = 0; l < WAY_W; l++) begin
      d          = ws[WAY_W-1];
      touch[node] = ~d;
      ws         = ws << 1;
      node       = (node << 1) + WAY_W'(1) + WAY_W'(d);
    end
  endfunction

  function automatic logic [NUM_WAYS-1:0] onehot(input logic [WAY_W-1:0] w);
    onehot = {{(NUM_WAYS-1){1'b0}}, 1'b1} << w;
  endfunction

  assign req = mem_read | mem_write;
  assign hit = |hit_vec;

  always_comb begin
    hit_way = '0;
    inv_way = '0;
    any_inv = 1'b0;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (hit_vec[i]) hit_way = WAY_W'(i);
      if (!valid_vec[i]) begin
        inv_way = WAY_W'(i);
        any_inv = 1'b1;
      end
    end
  end

  always_comb begin
    logic [WAY_W-1:0] node;
    logic             b;
    node     = '0;
    plru_way = '0;
    for (int l = 0; l < WAY_W; l++) begin
      b        = lru_bits[node];
      plru_way = (plru_way << 1) | WAY_W'(b);
      node     = (node << 1) + WAY_W'(1) + WAY_W'(b);
    end
  end

  assign miss_victim = any_inv ? inv_way : plru_way;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= CHECK;
      victim_q <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    victim_d = victim_q;
    case (state_q)
      CHECK: begin
        if (req && !hit) begin
          victim_d = miss_victim;
          state_d  = (dirty_vec[miss_victim] && valid_vec[miss_victim]) ? WRITE_BACK : FILL;
        end
      end
      WRITE_BACK: if (pmem_resp) state_d = FILL;
      FILL:       if (pmem_resp) state_d = INSTALL;
      INSTALL:    state_d = CHECK;
      default:    state_d = CHECK;
    endcase
  end

  always_comb begin
    mem_resp         = 1'b0;
    lru_load         = 1'b0;
    lru_new          = '0;
    way_sel          = '0;
    data_load        = '0;
    valid_set        = '0;
    dirty_set        = '0;
    dirty_clr        = '0;
    datawritemux_sel = 1'b0;
    pmemaddrmux_sel  = 1'b0;
    pmdr_load        = 1'b0;
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    if (!rst) begin
      case (state_q)
        CHECK: begin
          if (req && hit) begin
            mem_resp = 1'b1;
            way_sel  = hit_way;
            lru_load = 1'b1;
            lru_new  = touch(lru_bits, hit_way);
            if (mem_write) begin
              data_load        = onehot(hit_way);
              dirty_set        = onehot(hit_way);
              datawritemux_sel = 1'b1;
            end
          end
        end
        WRITE_BACK: begin
          pmem_write      = 1'b1;
          pmemaddrmux_sel = 1'b1;
          way_sel         = victim_q;
        end
        FILL: begin
          pmem_read = 1'b1;
          pmdr_load = 1'b1;
        end
        INSTALL: begin
          data_load = onehot(victim_q);
          valid_set = onehot(victim_q);
          dirty_clr = onehot(victim_q);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_control_nway.sv
// Randomised scoreboard bench for cache_control_nway with 4 ways.
// The driver emulates the datapath and memory and pushes the expected events. A negedge monitor pops and checks them.
module tb_cache_control_nway;
  localparam int N = 4;
  localparam int W = 2;

  localparam int K_WB   = 0;
  localparam int K_FILL = 1;
  localparam int K_INST = 2;
  localparam int K_RESP = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_read, mem_write, mem_resp;
  logic [N-1:0] hit_vec, valid_vec, dirty_vec;
  logic [N-2:0] lru_bits, lru_new;
  logic         lru_load;
  logic [W-1:0] way_sel;
  logic [N-1:0] data_load, valid_set, dirty_set, dirty_clr;
  logic         datawritemux_sel, pmemaddrmux_sel, pmdr_load, pmem_read, pmem_write, pmem_resp;

  cache_control_nway #(.NUM_WAYS(N)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
    .hit_vec(hit_vec), .valid_vec(valid_vec), .dirty_vec(dirty_vec), .lru_bits(lru_bits),
    .lru_load(lru_load), .lru_new(lru_new), .way_sel(way_sel), .data_load(data_load),
    .valid_set(valid_set), .dirty_set(dirty_set), .dirty_clr(dirty_clr),
    .datawritemux_sel(datawritemux_sel), .pmemaddrmux_sel(pmemaddrmux_sel),
    .pmdr_load(pmdr_load), .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       kind;
    int       way;
    bit [2:0] lru;
    bit       wr;
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference PLRU: a node-indexed heap, walked with plain arithmetic.
  function automatic int plru_victim(input bit [2:0] b);
    int node = 0;
    for (int l = 0; l < W; l++) node = 2 * node + 1 + int'(b[node]);
    return node - (N - 1);
  endfunction

  function automatic bit [2:0] touch_m(input bit [2:0] b, input int w);
    bit [2:0] r = b;
    for (int l = 0; l < W; l++) begin
      int node = (1 << l) - 1 + (w >> (W - l));
      int dir  = (w >> (W - 1 - l)) & 1;
      r[node] = (dir == 0);
    end
    return r;
  endfunction

  function automatic int lowest(input bit [3:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic push(input int kind, input int way, input bit [2:0] lru, input bit wr);
    ev_t e;
    e.kind = kind; e.way = way; e.lru = lru; e.wr = wr;
    exp_q.push_back(e);
  endtask

  task automatic pop_ev(input int kind, output ev_t e, output bit ok);
    checks++;
    ok = 1'b0;
    e  = '{default: 0};
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL unexpected_event: got kind %0d expected none at %0t", kind, $time);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind) begin
        failures++;
        $display("FAIL event_order: got kind %0d expected kind %0d at %0t", kind, e.kind, $time);
      end else ok = 1'b1;
    end
  endtask

  bit prev_rd = 0, prev_wr = 0;
  always @(negedge clk) begin
    ev_t      e;
    bit       ok;
    bit [3:0] oh;
    if (rst) begin
      prev_rd = 0;
      prev_wr = 0;
    end else begin
      if (pmem_read || pmem_write) chk("pmem_exclusive", pmem_read & pmem_write, 0);
      if (prev_rd) chk("pmem_read_hold", pmem_read, 1);
      if (prev_wr) chk("pmem_write_hold", pmem_write, 1);
      prev_rd = pmem_read && !pmem_resp;
      prev_wr = pmem_write && !pmem_resp;
      if (pmem_write && pmem_resp) begin
        pop_ev(K_WB, e, ok);
        if (ok) begin
          chk("wb_way_sel", way_sel, e.way);
          chk("wb_addrmux", pmemaddrmux_sel, 1);
        end
      end
      if (pmem_read && pmem_resp) begin
        pop_ev(K_FILL, e, ok);
        if (ok) begin
          chk("fill_pmdr_load", pmdr_load, 1);
          chk("fill_addrmux", pmemaddrmux_sel, 0);
        end
      end
      if (valid_set != 0) begin
        pop_ev(K_INST, e, ok);
        if (ok) begin
          oh = 4'b0001 << e.way;
          chk("install_valid_set", valid_set, oh);
          chk("install_data_load", data_load, oh);
          chk("install_dirty_clr", dirty_clr, oh);
          chk("install_wmux", datawritemux_sel, 0);
          chk("install_no_lru", lru_load, 0);
        end
      end
      if (mem_resp) begin
        pop_ev(K_RESP, e, ok);
        if (ok) begin
          oh = 4'b0001 << e.way;
          chk("resp_way_sel", way_sel, e.way);
          chk("resp_lru_load", lru_load, 1);
          chk("resp_lru_new", lru_new, e.lru);
          chk("resp_data_load", data_load, e.wr ? oh : 4'b0000);
          chk("resp_dirty_set", dirty_set, e.wr ? oh : 4'b0000);
          chk("resp_wmux", datawritemux_sel, e.wr);
        end
      end
    end
  end

  task automatic do_req(input bit rd, input bit wr, input bit [3:0] hv, input bit [3:0] vv,
                        input bit [3:0] dv, input bit [2:0] lb, input int delay);
    int       wait_cnt = 0;
    bit       done = 0;
    bit       fin;
    bit [3:0] inst_oh;
    if (hv != 0) begin
      push(K_RESP, lowest(hv), touch_m(lb, lowest(hv)), wr);
    end else begin
      int vic = (vv != 4'b1111) ? lowest(~vv) : plru_victim(lb);
      if (vv[vic] && dv[vic]) push(K_WB, vic, 3'b000, wr);
      push(K_FILL, vic, 3'b000, wr);
      push(K_INST, vic, 3'b000, wr);
      push(K_RESP, vic, touch_m(lb, vic), wr);
    end
    @(posedge clk); #1;
    mem_read = rd; mem_write = wr; hit_vec = hv; valid_vec = vv; dirty_vec = dv; lru_bits = lb;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      #1;
      if (cyc == 0 && hv != 0) chk("hit_latency", mem_resp, 1);
      fin     = mem_resp;
      inst_oh = valid_set;
      if (pmem_read || pmem_write) begin
        if (wait_cnt >= delay) pmem_resp = 1'b1;
        else wait_cnt++;
      end
      @(posedge clk); #1;
      if (pmem_resp) begin
        pmem_resp = 1'b0;
        wait_cnt  = 0;
      end
      if (inst_oh != 0) begin
        hit_vec   = inst_oh;
        valid_vec = valid_vec | inst_oh;
        dirty_vec = dirty_vec & ~inst_oh;
      end
      if (fin) begin
        done = 1;
        mem_read = 0; mem_write = 0; hit_vec = 0;
      end
    end
    chk("req_timeout", done, 1);
  endtask

  initial begin
    bit got;
    rst = 1; mem_read = 1; mem_write = 0; hit_vec = 4'b0100; valid_vec = 4'b1111;
    dirty_vec = 4'b1111; lru_bits = 3'b000; pmem_resp = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_mem_resp", mem_resp, 0);
    chk("rst_lru_load", lru_load, 0);
    chk("rst_data_load", data_load, 0);
    chk("rst_pmem", {pmem_read, pmem_write}, 0);
    @(posedge clk); #1;
    rst = 0; mem_read = 0; hit_vec = 0;

    do_req(1, 0, 4'b0100, 4'b1111, 4'b0000, 3'b000, 0);
    do_req(0, 1, 4'b0010, 4'b1111, 4'b0000, 3'b000, 0);
    do_req(1, 0, 4'b0000, 4'b1111, 4'b0000, 3'b011, 4);
    do_req(0, 1, 4'b0000, 4'b1111, 4'b0001, 3'b000, 2);
    do_req(1, 0, 4'b0000, 4'b1011, 4'b0001, 3'b000, 1);

    // Reset while FILL is waiting on memory.
    @(posedge clk); #1;
    mem_read = 1; hit_vec = 0; valid_vec = 4'b1011; dirty_vec = 4'b0001; lru_bits = 0;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      #1;
      if (pmem_read) got = 1;
      else begin @(posedge clk); #1; end
    end
    chk("rst_fill_reached", got, 1);
    @(posedge clk); #1;
    rst = 1;
    #1;
    chk("rstfill_pmem_read", pmem_read, 0);
    chk("rstfill_mem_resp", mem_resp, 0);
    @(posedge clk); #1;
    rst = 0; mem_read = 0;
    #1;
    chk("postrst_pmem_read", pmem_read, 0);
    chk("postrst_data_load", data_load, 0);
    chk("postrst_mem_resp", mem_resp, 0);
    do_req(1, 0, 4'b1000, 4'b1111, 4'b0000, 3'b101, 0);

    for (int t = 0; t < 150; t++) begin
      int       k  = $urandom_range(0, 3);
      bit [3:0] vv = 4'($urandom);
      bit [3:0] dv = 4'($urandom) & vv;
      bit [2:0] lb = 3'($urandom);
      bit [3:0] hv = ($urandom_range(0, 1) == 1) ? (vv & 4'($urandom)) : 4'b0000;
      do_req(k != 2, k >= 2, hv, vv, dv, lb, $urandom_range(0, 4));
    end

    @(posedge clk); @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
